// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin share of one bin2bcd converter, 4-digit mux display.
// Optional DISP_LZ_BLANK_EN blanks leading zeros on hundreds/tens digits.
module disp_arbiter #(
  parameter int HOLD_CYC    = 25_000_000,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [9:0] din0,
  input  logic [9:0] din1,
  input  logic [9:0] din2,
  output logic [2:0] ack,
  output logic [9:0] bin,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       neg,
  output logic       busy,
  output logic [1:0] src,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  logic [1:0]    state;
  logic [1:0]    last_grant;
  logic [1:0]    grant;
  logic [1:0]    win;
  logic [9:0]    win_din;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    dig;
  logic [3:0]    d2;
  logic [3:0]    d1;
  logic [3:0]    d0;
  logic          dneg;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign busy = (state != S_IDLE);

  // round-robin pick: search starts one past the last granted source
  always_comb begin
    win = 2'd0;
    unique case (last_grant)
      2'd0:
        win = req[1] ? 2'd1 :
              req[2] ? 2'd2 : 2'd0;
      2'd1:
        win = req[2] ? 2'd2 :
              req[0] ? 2'd0 : 2'd1;
      default:
        win = req[0] ? 2'd0 :
              req[1] ? 2'd1 : 2'd2;
    endcase
  end

  // value of the winning source
  always_comb begin
    win_din = din0;
    case (win)
      2'd0:    win_din = din0;
      2'd1:    win_din = din1;
      default: win_din = din2;
    endcase
  end

  // grant / settle / hold sequencer and converter capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 2'd2;
      grant      <= 2'd0;
      ack        <= 3'b000;
      bin        <= 10'd0;
      src        <= 2'd0;
      hold_cnt   <= '0;
      d2         <= 4'd0;
      d1         <= 4'd0;
      d0         <= 4'd0;
      dneg       <= 1'b0;
    end else begin
      ack <= 3'b000;
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            bin        <= win_din;
            ack        <= 3'b001 << win;
            grant      <= win;
            last_grant <= win;
            state      <= S_CONV;
          end
        end
        S_CONV: begin
          d2       <= bcd2;
          d1       <= bcd1;
          d0       <= bcd0;
          dneg     <= neg;
          src      <= grant;
          hold_cnt <= '0;
          state    <= S_HOLD;
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // digit scan timer, free-running regardless of the sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      dig     <= 2'd0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      dig     <= dig + 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // pick nibble and leading-zero blanking for the scanned digit
  always_comb begin
    nib   = d0;
    blank = 1'b0;
    case (dig)
      2'd2: begin
        nib = d2;
`ifdef DISP_LZ_BLANK_EN
        blank = (d2 == 4'd0);
`endif
      end
      2'd1: begin
        nib = d1;
`ifdef DISP_LZ_BLANK_EN
        blank = (d2 == 4'd0) && (d1 == 4'd0);
`endif
      end
      default: nib = d0;
    endcase
  end

  // segment pattern for the scanned digit
  always_comb begin
    seg_nxt = SEG_BLANK;
    if (dig == 2'd3)
      seg_nxt = dneg ? SEG_MINUS : SEG_BLANK;
    else if (blank)
      seg_nxt = SEG_BLANK;
    else
      seg_nxt = hex7(nib);
  end

  // registered anode/segment drive, one cycle behind dig
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << dig);
      seg <= seg_nxt;
    end
  end

endmodule
